// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter: FSM encoding,
// digit width and the default input-width / digit-count pairing.
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int BCD_W = 4;

  // 16 bits needs 5 digits: 10**5 > 65535.
  localparam int DEF_BIT_SZ = 16;
  localparam int DEF_DIGITS = 5;

endpackage

// File: rtl/bcd_adj3.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more so the
// following left shift carries into the next digit correctly.
module bcd_adj3
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] d,
  output logic [BCD_W-1:0] q
);

  always_comb begin
    q = d;
    if (d >= BCD_W'(5)) begin
      q = d + BCD_W'(3);
    end
  end

endmodule

// File: rtl/bcd_conv_16.sv
// Sequential binary-to-BCD converter, one input bit per cycle (shift-add-3).
// load in IDLE starts a conversion; done pulses when bcd_out is updated.
module bcd_conv_16
  import bcd_pkg::*;
#(
  parameter int BIT_SZ = DEF_BIT_SZ,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic                    sysclk,
  input  logic                    sreset,
  input  logic                    load,
  input  logic [BIT_SZ-1:0]       bin_in,
  output logic [BCD_W*DIGITS-1:0] bcd_out,
  output logic                    busy,
  output logic                    done
);

  localparam int SCR_W = BCD_W * DIGITS;
  localparam int CNT_W = $clog2(BIT_SZ);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_SZ - 1);

  state_t           state;
  logic [BIT_SZ-1:0] shift_reg;
  logic [SCR_W-1:0]  scratch;
  logic [SCR_W-1:0]  scratch_adj;
  logic [CNT_W-1:0]  bit_cnt;

  // Every digit is corrected in parallel before each shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_adj3 u_adj (
      .d (scratch[g*BCD_W +: BCD_W]),
      .q (scratch_adj[g*BCD_W +: BCD_W])
    );
  end

  assign busy = (state != ST_IDLE);

  always_ff @(posedge sysclk) begin
    if (sreset) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      scratch   <= '0;
      bit_cnt   <= '0;
      bcd_out   <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load) begin
            shift_reg <= bin_in;
            scratch   <= '0;
            bit_cnt   <= '0;
            state     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // {scratch, shift_reg} shifts left as one register, MSB of the
          // binary value entering the units digit.
          scratch   <= {scratch_adj[SCR_W-2:0], shift_reg[BIT_SZ-1]};
          shift_reg <= {shift_reg[BIT_SZ-2:0], 1'b0};
          bit_cnt   <= bit_cnt + 1'b1;
          if (bit_cnt == CNT_LAST) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          bcd_out <= scratch;
          done    <= 1'b1;
          state   <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
